// File: rtl/matmul_serial_param.sv
// N x N unsigned matrix multiply C = A x B through one shared MAC, one product per cycle.
// Build option MATMUL_SAT_EN: clamp oversized result elements to all ones instead of wrapping.
module matmul_serial_param #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int OW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N*N*DW-1:0] A_flat,
  input  logic [N*N*DW-1:0] B_flat,
  output logic [N*N*OW-1:0] C_flat,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam int AW = 2*DW + $clog2(N);
  localparam int IW = $clog2(N);
  localparam int NE = N*N;
  localparam logic [IW-1:0] LAST = IW'(N-1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [NE*DW-1:0]    r_a, r_b;
  logic [NE*OW-1:0]    r_c;
  logic [AW-1:0]       r_acc;
  logic [IW-1:0]       r_i, r_j, r_k;
  logic                r_ovf;

  logic                w_accept, w_k_last, w_last_el;
  int                  w_aidx, w_bidx, w_cidx;
  logic [DW-1:0]       w_a_el, w_b_el;
  logic [AW-1:0]       w_acc_next;
  logic [OW-1:0]       w_conv;
  logic                w_ovf_el;

  assign w_accept  = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_k_last  = (r_k == LAST);
  assign w_last_el = w_k_last && (r_j == LAST) && (r_i == LAST);

  always_comb begin
    w_aidx = NE - 1 - (int'(r_i) * N + int'(r_k));
    w_bidx = NE - 1 - (int'(r_k) * N + int'(r_j));
    w_cidx = NE - 1 - (int'(r_i) * N + int'(r_j));
  end

  assign w_a_el     = r_a[w_aidx*DW +: DW];
  assign w_b_el     = r_b[w_bidx*DW +: DW];
  // AW leaves room for N full-scale products, so the sum can never wrap.
  assign w_acc_next = ((r_k == '0) ? '0 : r_acc) + AW'(w_a_el) * AW'(w_b_el);

  generate
    if (OW >= AW) begin : g_ext
      assign w_conv   = OW'(w_acc_next);
      assign w_ovf_el = 1'b0;
    end else begin : g_narrow
      assign w_ovf_el = |w_acc_next[AW-1:OW];
`ifdef MATMUL_SAT_EN
      assign w_conv   = w_ovf_el ? '1 : w_acc_next[OW-1:0];
`else
      assign w_conv   = w_acc_next[OW-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_MAC;
      S_MAC:   if (w_last_el) w_next = S_DONE;
      S_DONE:  if (w_accept) w_next = S_MAC;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_a   <= A_flat;
      r_b   <= B_flat;
      r_c   <= '0;
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == S_MAC) begin
      r_acc <= w_acc_next;
      if (w_k_last) begin
        r_c[w_cidx*OW +: OW] <= w_conv;
        if (w_ovf_el) r_ovf <= 1'b1;
        r_k <= '0;
        if (r_j == LAST) begin
          r_j <= '0;
          r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  assign C_flat   = r_c;
  assign overflow = r_ovf;
  assign busy     = (r_state == S_MAC);
  assign done     = (r_state == S_DONE);
endmodule

// File: tb/tb_matmul_serial_param.sv
// Scoreboard bench for matmul_serial_param: N=3 main instance plus an N=4 instance.
module tb_matmul_serial_param;
  localparam int N = 3, DW = 8, OW = 16;
  localparam int N4 = 4;

  logic clk = 1'b0;
  logic reset, start, start4;
  logic [N*N*DW-1:0]   A_flat, B_flat;
  logic [N*N*OW-1:0]   C_flat;
  logic                busy, done, overflow;
  logic [N4*N4*DW-1:0] A4, B4;
  logic [N4*N4*OW-1:0] C4;
  logic                busy4, done4, ovf4;

  always #5 clk = ~clk;

  matmul_serial_param #(.N(N), .DW(DW), .OW(OW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .A_flat(A_flat), .B_flat(B_flat),
    .C_flat(C_flat), .busy(busy), .done(done), .overflow(overflow));

  matmul_serial_param #(.N(N4), .DW(DW), .OW(OW)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .A_flat(A4), .B_flat(B4),
    .C_flat(C4), .busy(busy4), .done(done4), .overflow(ovf4));

  typedef struct {
    logic [255:0] c;
    logic         ovf;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_model(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b);
    exp_t e;
    int acc;
    logic [OW-1:0] el;
    e.c = '0;
    e.ovf = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        acc = 0;
        for (int k = 0; k < N; k++)
          acc += int'(a[(N*N-1-(r*N+k))*DW +: DW]) * int'(b[(N*N-1-(k*N+c))*DW +: DW]);
        el = acc[OW-1:0];
        if (acc > 65535) begin
          e.ovf = 1'b1;
`ifdef MATMUL_SAT_EN
          el = 16'hFFFF;
`endif
        end
        e.c[(N*N-1-(r*N+c))*OW +: OW] = el;
      end
    end
    sb.push_back(e);
  endtask

  // Drives operands and start, then steps past the accepting edge; start is left high.
  task automatic launch(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b);
    A_flat = a;
    B_flat = b;
    push_model(a, b);
    start = 1'b1;
    @(posedge clk); #1;
    chk("accept_clr", C_flat, '0);
    chk("accept_done", done, 1'b0);
    chk("accept_busy", busy, 1'b1);
  endtask

  task automatic wait_done(input int lat_exp);
    int cnt = 0;
    int gap = 0;
    exp_t e;
    while (!done && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
      if (!busy && !done) gap++;
    end
    chk("latency", cnt, lat_exp);
    chk("busy_gap", gap, 0);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("C_flat", C_flat, e.c);
      chk("overflow", overflow, e.ovf);
    end
  endtask

  logic [N*N*DW-1:0]   a1, b1, aff;
  logic [N*N*OW-1:0]   c1_spec;
  logic [N4*N4*OW-1:0] c4_exp;
  logic [OW-1:0]       el_ff;
  exp_t                drop;
  int                  spec1 [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
  int                  cnt4;

  initial begin
    reset = 1'b0; start = 1'b0; start4 = 1'b0;
    A_flat = '0; B_flat = '0; A4 = '0; B4 = '0;
    for (int n = 0; n < 9; n++) begin
      a1[(8-n)*DW +: DW] = DW'(n + 1);
      b1[(8-n)*DW +: DW] = DW'(9 - n);
      c1_spec[(8-n)*OW +: OW] = OW'(spec1[n]);
    end
    aff = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_C", C_flat, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    // basic 1..9 x 9..1
    launch(a1, b1);
    start = 1'b0;
    wait_done(27);
    chk("spec_C1", C_flat, c1_spec);

    // all-ones operands overflow
    launch(aff, aff);
    start = 1'b0;
    wait_done(27);
`ifdef MATMUL_SAT_EN
    el_ff = 16'd65535;
`else
    el_ff = 16'd64003;
`endif
    chk("ff_el00", C_flat[(N*N-1)*OW +: OW], el_ff);

    // start held through the run, then re-accepted at the first DONE edge
    launch(a1, a1);
    wait_done(27);
    A_flat = b1;
    B_flat = a1;
    push_model(b1, a1);
    @(posedge clk); #1;
    chk("reacc_done", done, 1'b0);
    chk("reacc_busy", busy, 1'b1);
    chk("reacc_clr", C_flat, '0);
    start = 1'b0;
    wait_done(27);

    // reset mid-run
    launch(aff, b1);
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    drop = sb.pop_back();
    chk("mid_rst_C", C_flat, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_done", done, 1'b0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    launch(a1, b1);
    start = 1'b0;
    wait_done(27);
    chk("spec_C1_again", C_flat, c1_spec);

    // back-to-back from DONE with new operands
    launch(b1, aff);
    start = 1'b0;
    wait_done(27);

    // N=4 identity x 1..16, operands zeroed after accept
    c4_exp = '0;
    for (int r = 0; r < N4; r++)
      for (int c = 0; c < N4; c++) begin
        A4[(15-(r*N4+c))*DW +: DW] = (r == c) ? 8'd1 : 8'd0;
        B4[(15-(r*N4+c))*DW +: DW] = DW'(r*N4 + c + 1);
        c4_exp[(15-(r*N4+c))*OW +: OW] = OW'(r*N4 + c + 1);
      end
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    cnt4 = 0;
    while (!done4 && cnt4 < 400) begin
      @(posedge clk); #1;
      cnt4++;
      if (cnt4 == 1) begin
        A4 = '0;
        B4 = '0;
      end
    end
    chk("n4_latency", cnt4, 64);
    chk("n4_C", C4, c4_exp);
    chk("n4_ovf", ovf4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
